// File: rtl/booth8x8_pp_accumulator_if.sv
// Handshake and row bus between the Booth encoder / sign-extension stage and
// the sequential partial-product accumulator.
interface booth8x8_pp_accumulator_if;
  logic               in_valid;
  logic               in_ready;
  logic        [11:0] pp00;
  logic        [12:0] pp01;
  logic        [12:0] pp02;
  logic        [11:0] pp03;
  logic               neg3;
  logic               out_valid;
  logic               out_ready;
  logic signed [15:0] product;
  logic               busy;

  modport master (
    output in_valid, pp00, pp01, pp02, pp03, neg3, out_ready,
    input  in_ready, out_valid, product, busy
  );

  modport slave (
    input  in_valid, pp00, pp01, pp02, pp03, neg3, out_ready,
    output in_ready, out_valid, product, busy
  );
endinterface

// File: rtl/booth8x8_pp_accumulator.sv
// Sequential accumulator for the four sign-extension-encoded radix-4 Booth rows
// of a signed 8x8 multiply: one row added per cycle into a wrapping 16-bit sum.
module booth8x8_pp_accumulator (
  input  logic                            clk,
  input  logic                            rst,
  booth8x8_pp_accumulator_if.slave        bus
);

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  state_t             state;
  logic        [1:0]  cnt;
  logic signed [15:0] acc;
  logic               busy_r;
  logic               out_valid_r;

  logic        [11:0] pp00_r;
  logic        [12:0] pp01_r;
  logic        [12:0] pp02_r;
  logic        [11:0] pp03_r;
  logic               neg3_r;

  logic               accept;
  logic signed [15:0] term;

  // Aligns row idx to its weight inside the 16-bit sum; neg3 rides on row 0.
  function automatic logic signed [15:0] row_term(
    input logic [1:0]  idx,
    input logic [11:0] r0,
    input logic [12:0] r1,
    input logic [12:0] r2,
    input logic [11:0] r3,
    input logic        n3
  );
    logic [15:0] t;
    case (idx)
      2'd0:    t = {4'b0, r0} + {9'b0, n3, 6'b0};
      2'd1:    t = {3'b0, r1};
      2'd2:    t = {1'b0, r2, 2'b0};
      default: t = {r3, 4'b0};
    endcase
    return signed'(t);
  endfunction

  assign bus.in_ready  = (state == IDLE) || ((state == DONE) && bus.out_ready);
  assign accept        = bus.in_valid && bus.in_ready;
  assign bus.busy      = busy_r;
  assign bus.out_valid = out_valid_r;
  assign bus.product   = acc;

  assign term = row_term(cnt, pp00_r, pp01_r, pp02_r, pp03_r, neg3_r);

  // Row capture: data only, sampled on the accepting edge.
  always_ff @(posedge clk) begin
    if (accept) begin
      pp00_r <= bus.pp00;
      pp01_r <= bus.pp01;
      pp02_r <= bus.pp02;
      pp03_r <= bus.pp03;
      neg3_r <= bus.neg3;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= 2'd0;
      acc         <= '0;
      busy_r      <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            state  <= ACC;
            acc    <= '0;
            cnt    <= 2'd0;
            busy_r <= 1'b1;
          end
        end
        ACC: begin
          // Carry out of bit 15 is dropped so the sign-extension constants cancel.
          acc <= acc + term;
          cnt <= cnt + 2'd1;
          if (cnt == 2'd3) begin
            state       <= DONE;
            busy_r      <= 1'b0;
            out_valid_r <= 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            if (bus.in_valid) begin
              state  <= ACC;
              acc    <= '0;
              cnt    <= 2'd0;
              busy_r <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: begin
          state       <= IDLE;
          busy_r      <= 1'b0;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth8x8_pp_accumulator.sv
// Directed bench for booth8x8_pp_accumulator: alignment, wrap, signed corners,
// backpressure, back-to-back and asynchronous reset mid-accumulation.
module tb_booth8x8_pp_accumulator;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  booth8x8_pp_accumulator_if bif ();

  booth8x8_pp_accumulator dut (
    .clk (clk),
    .rst (rst),
    .bus (bif.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rows(input logic [11:0] r0, input logic [12:0] r1,
                          input logic [12:0] r2, input logic [11:0] r3,
                          input logic n3);
    bif.pp00 = r0;
    bif.pp01 = r1;
    bif.pp02 = r2;
    bif.pp03 = r3;
    bif.neg3 = n3;
  endtask

  task automatic scramble_rows();
    set_rows(12'hFFF, 13'h1FFF, 13'h1FFF, 12'hFFF, 1'b1);
  endtask

  // One complete transaction from IDLE with out_ready held high.
  task automatic run_op(input string name, input logic [11:0] r0, input logic [12:0] r1,
                        input logic [12:0] r2, input logic [11:0] r3, input logic n3,
                        input logic [15:0] exp);
    int n;
    bit seen;
    bif.out_ready = 1'b1;
    set_rows(r0, r1, r2, r3, n3);
    bif.in_valid = 1'b1;
    n_cmp++;
    if (bif.in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL %s in_ready_idle: got %b want 1", name, bif.in_ready);
    end
    tick();
    bif.in_valid = 1'b0;
    scramble_rows();
    n_cmp++;
    if (bif.busy !== 1'b1 || bif.in_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL %s busy_acc: got busy=%b in_ready=%b want 1/0", name, bif.busy, bif.in_ready);
    end
    n = 0;
    seen = 1'b0;
    while (!seen && n < 12) begin
      tick();
      n++;
      if (bif.out_valid === 1'b1) seen = 1'b1;
    end
    n_cmp++;
    if (!seen || n != 4) begin
      n_bad++;
      $display("FAIL %s latency: got %0d edges (seen=%b) want 4", name, n, seen);
    end
    n_cmp++;
    if (bif.product !== exp) begin
      n_bad++;
      $display("FAIL %s product: got %h want %h", name, bif.product, exp);
    end
    tick();
    n_cmp++;
    if (bif.out_valid !== 1'b0 || bif.product !== exp) begin
      n_bad++;
      $display("FAIL %s idle_hold: got valid=%b product=%h want 0/%h", name, bif.out_valid, bif.product, exp);
    end
  endtask

  task automatic test_reset();
    n_cmp++;
    if (bif.product !== 16'h0000 || bif.out_valid !== 1'b0 || bif.busy !== 1'b0 || bif.in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_state: got product=%h valid=%b busy=%b in_ready=%b want 0000/0/0/1",
               bif.product, bif.out_valid, bif.busy, bif.in_ready);
    end
  endtask

  task automatic test_alignment();
    run_op("align_pp00", 12'h005, 13'h0000, 13'h0000, 12'h000, 1'b0, 16'h0005);
    run_op("align_pp03", 12'h000, 13'h0000, 13'h0000, 12'h001, 1'b0, 16'h0010);
    run_op("align_pp02", 12'h000, 13'h0000, 13'h0001, 12'h000, 1'b0, 16'h0004);
    run_op("align_neg3", 12'h000, 13'h0000, 13'h0000, 12'h000, 1'b1, 16'h0040);
  endtask

  task automatic test_wrap();
    run_op("wrap_zero", 12'h800, 13'h1800, 13'h1800, 12'h800, 1'b0, 16'h0000);
  endtask

  task automatic test_signed_corners();
    run_op("m128_m128", 12'h800, 13'h1800, 13'h1800, 12'hBFC, 1'b1, 16'h4000);
    run_op("m128_p127", 12'h87F, 13'h1801, 13'h1800, 12'h400, 1'b0, 16'hC080);
    run_op("p127_p127", 12'h780, 13'h1801, 13'h1800, 12'hBF8, 1'b0, 16'h3F01);
    run_op("m1_m1",     12'h800, 13'h1801, 13'h1800, 12'h800, 1'b0, 16'h0001);
  endtask

  task automatic test_backpressure();
    int n;
    bit seen;
    bif.out_ready = 1'b0;
    set_rows(12'h780, 13'h1801, 13'h1800, 12'hBF8, 1'b0);
    bif.in_valid = 1'b1;
    tick();
    bif.in_valid = 1'b0;
    scramble_rows();
    n = 0;
    seen = 1'b0;
    while (!seen && n < 12) begin
      tick();
      n++;
      if (bif.out_valid === 1'b1) seen = 1'b1;
    end
    n_cmp++;
    if (!seen || n != 4) begin
      n_bad++;
      $display("FAIL bp_latency: got %0d edges (seen=%b) want 4", n, seen);
    end
    set_rows(12'h800, 13'h1801, 13'h1800, 12'h800, 1'b0);
    bif.in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      n_cmp++;
      if (bif.out_valid !== 1'b1 || bif.product !== 16'h3F01 || bif.in_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL bp_hold[%0d]: got valid=%b product=%h in_ready=%b want 1/3f01/0",
                 i, bif.out_valid, bif.product, bif.in_ready);
      end
      tick();
    end
    bif.out_ready = 1'b1;
    #1;
    n_cmp++;
    if (bif.in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL bp_release_in_ready: got %b want 1", bif.in_ready);
    end
    tick();
    bif.in_valid = 1'b0;
    scramble_rows();
    n = 0;
    seen = 1'b0;
    while (!seen && n < 12) begin
      tick();
      n++;
      if (bif.out_valid === 1'b1) seen = 1'b1;
    end
    n_cmp++;
    if (!seen || n != 4 || bif.product !== 16'h0001) begin
      n_bad++;
      $display("FAIL bp_second: got %0d edges product=%h want 4/0001", n, bif.product);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int nv;
    int v1;
    int v2;
    logic [15:0] p1;
    logic [15:0] p2;
    nv = 0;
    v1 = -1;
    v2 = -1;
    p1 = '0;
    p2 = '0;
    bif.out_ready = 1'b1;
    set_rows(12'h800, 13'h1800, 13'h1800, 12'hBFC, 1'b1);
    bif.in_valid = 1'b1;
    tick();
    set_rows(12'h87F, 13'h1801, 13'h1800, 12'h400, 1'b0);
    for (int n = 1; n <= 12; n++) begin
      tick();
      if (bif.out_valid === 1'b1) begin
        nv++;
        if (v1 < 0) begin
          v1 = n;
          p1 = bif.product;
        end else begin
          v2 = n;
          p2 = bif.product;
          bif.in_valid = 1'b0;
        end
      end
    end
    bif.in_valid = 1'b0;
    n_cmp++;
    if (nv != 2) begin
      n_bad++;
      $display("FAIL b2b_count: got %0d valid cycles want 2", nv);
    end
    n_cmp++;
    if (v1 != 4 || p1 !== 16'h4000) begin
      n_bad++;
      $display("FAIL b2b_first: got cycle %0d product=%h want 4/4000", v1, p1);
    end
    n_cmp++;
    if (v2 != 9 || p2 !== 16'hC080) begin
      n_bad++;
      $display("FAIL b2b_second: got cycle %0d product=%h want 9/c080", v2, p2);
    end
  endtask

  task automatic test_reset_mid_acc();
    bit spurious;
    bif.out_ready = 1'b1;
    set_rows(12'h780, 13'h1801, 13'h1800, 12'hBF8, 1'b0);
    bif.in_valid = 1'b1;
    tick();
    bif.in_valid = 1'b0;
    tick();
    tick();
    #1;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (bif.out_valid !== 1'b0 || bif.product !== 16'h0000 || bif.in_ready !== 1'b1 || bif.busy !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_async: got valid=%b product=%h in_ready=%b busy=%b want 0/0000/1/0",
               bif.out_valid, bif.product, bif.in_ready, bif.busy);
    end
    #1;
    rst = 1'b0;
    spurious = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bif.out_valid !== 1'b0) spurious = 1'b1;
    end
    n_cmp++;
    if (spurious !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_no_emit: got spurious out_valid=%b want 0", spurious);
    end
    run_op("post_rst", 12'h800, 13'h1801, 13'h1800, 12'h800, 1'b0, 16'h0001);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    bif.in_valid = 1'b0;
    bif.out_ready = 1'b1;
    set_rows(12'h000, 13'h0000, 13'h0000, 12'h000, 1'b0);
    #12;
    test_reset();
    rst = 1'b0;
    tick();
    test_alignment();
    test_wrap();
    test_signed_corners();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_acc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
